// File: rtl/pc_redirect_if.sv
// pc_redirect_if: PC-source request/response bundle between the fetch datapath and pc_redirect_ctrl
interface pc_redirect_if #(parameter int AW = 32);
    logic [AW-1:0] pc_cur;
    logic [3:0]    opcode;
    logic          stall;
    logic          exception;
    logic          interrupt;
    logic          set_int;
    logic          pop_pc;
    logic [AW-1:0] pc_popped;
    logic          jmp_sgn;
    logic [AW-1:0] pc_jmp;
    logic          push_ack;
    logic [AW-1:0] pc_next;
    logic          pc_load;
    logic          fetch_nop;
    logic          int_push;
    logic [AW-1:0] int_ret_pc;
    logic          int_flag;
    logic          busy;
    modport master (
        output pc_cur, opcode, stall, exception, interrupt, set_int, pop_pc, pc_popped, jmp_sgn, pc_jmp, push_ack,
        input  pc_next, pc_load, fetch_nop, int_push, int_ret_pc, int_flag, busy
    );
    modport slave (
        input  pc_cur, opcode, stall, exception, interrupt, set_int, pop_pc, pc_popped, jmp_sgn, pc_jmp, push_ack,
        output pc_next, pc_load, fetch_nop, int_push, int_ret_pc, int_flag, busy
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: arbitrates PC redirects and sequences interrupt entry for the fetch stage
module pc_redirect_ctrl #(
    parameter int            AW        = 32,
    parameter logic [AW-1:0] RESET_VEC = 32,
    parameter logic [AW-1:0] INT_VEC   = 0,
    parameter logic [3:0]    IMM_OPC   = 4'd8
) (
    input logic          clk,
    input logic          reset,
    pc_redirect_if.slave bus
);
    typedef enum logic [2:0] {S_RST, S_RUN, S_IMM, S_INT_PUSH, S_INT_VEC} state_t;
    state_t        r_state;
    state_t        w_state_nx;
    logic          r_int_pend;
    logic [AW-1:0] r_int_ret_pc;
    logic          w_redir;
    logic [AW-1:0] w_redir_pc;
    logic [AW-1:0] w_pc_next;
    logic          w_pc_load;
    logic          w_fetch_nop;
    logic          w_int_push;
    logic          w_int_flag;
    logic          w_capture;
    assign w_redir    = bus.exception | bus.pop_pc | bus.jmp_sgn;
    assign w_redir_pc = bus.exception ? RESET_VEC : bus.pop_pc ? bus.pc_popped : bus.pc_jmp;
    // Next state and PC-source outputs; redirects beat stall, the immediate word never takes an interrupt
    always_comb begin
        w_state_nx  = r_state;
        w_pc_next   = bus.pc_cur + AW'(1);
        w_pc_load   = 1'b0;
        w_fetch_nop = 1'b0;
        w_int_push  = 1'b0;
        w_int_flag  = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_RST: begin
                w_pc_next   = RESET_VEC;
                w_pc_load   = 1'b1;
                w_fetch_nop = 1'b1;
                w_state_nx  = S_RUN;
            end
            S_RUN, S_IMM: begin
                if (w_redir) begin
                    w_pc_next   = w_redir_pc;
                    w_pc_load   = 1'b1;
                    w_fetch_nop = 1'b1;
                    w_state_nx  = S_RUN;
                end else if (r_state == S_RUN && r_int_pend && !bus.stall) begin
                    w_fetch_nop = 1'b1;
                    w_capture   = 1'b1;
                    w_state_nx  = S_INT_PUSH;
                end else if (!bus.stall) begin
                    w_pc_load  = 1'b1;
                    w_state_nx = (r_state == S_RUN && bus.opcode == IMM_OPC) ? S_IMM : S_RUN;
                end
            end
            S_INT_PUSH: begin
                w_fetch_nop = 1'b1;
                if (bus.exception) begin
                    w_pc_next  = RESET_VEC;
                    w_pc_load  = 1'b1;
                    w_state_nx = S_RUN;
                end else begin
                    w_int_push = !reset;
                    w_state_nx = bus.push_ack ? S_INT_VEC : S_INT_PUSH;
                end
            end
            S_INT_VEC: begin
                w_fetch_nop = 1'b1;
                w_pc_load   = 1'b1;
                w_pc_next   = bus.exception ? RESET_VEC : INT_VEC;
                w_int_flag  = !bus.exception;
                w_state_nx  = S_RUN;
            end
            default: w_state_nx = S_RST;
        endcase
    end
    // State, pending interrupt and return PC update on the falling edge alongside the PC register
    always_ff @(negedge clk) begin
        if (reset) begin
            r_state      <= S_RST;
            r_int_pend   <= 1'b0;
            r_int_ret_pc <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_int_pend <= (w_capture | bus.exception) ? 1'b0 : (r_int_pend | bus.interrupt | bus.set_int);
            if (w_capture) r_int_ret_pc <= bus.pc_cur;
        end
    end
    assign bus.pc_next    = w_pc_next;
    assign bus.pc_load    = w_pc_load;
    assign bus.fetch_nop  = w_fetch_nop;
    assign bus.int_push   = w_int_push;
    assign bus.int_ret_pc = r_int_ret_pc;
    assign bus.int_flag   = w_int_flag;
    assign bus.busy       = r_state != S_RUN;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: vector table plus hand sequences, scoreboarded against pc_redirect_ctrl
module tb_pc_redirect_ctrl;
    localparam logic [6:0] ST = 7'h40, EX = 7'h20, IN = 7'h10, SI = 7'h08, PP = 7'h04, JP = 7'h02, AK = 7'h01;
    localparam logic [4:0] L = 5'h10, N = 5'h08, P = 5'h04, F = 5'h02, B = 5'h01;
    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic [3:0]  opc;
        logic [6:0]  in;
        logic [31:0] pcj;
        logic [31:0] nxt;
        logic [4:0]  out;
        logic [31:0] ret;
    } vec_t;
    typedef struct {
        logic [31:0] nxt;
        logic [4:0]  out;
        logic [31:0] ret;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_run = 0;
    int n_fail = 0;
    int n_step = 0;
    vec_t vecs[$];
    exp_t sb[$];
    pc_redirect_if #(.AW(32)) bus();
    pc_redirect_ctrl #(.AW(32), .RESET_VEC(32'd32), .INT_VEC(32'd0), .IMM_OPC(4'd8)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    function automatic vec_t mk(logic r, logic [31:0] pc, logic [3:0] opc, logic [6:0] in,
                                logic [31:0] pcj, logic [31:0] nxt, logic [4:0] out, logic [31:0] ret);
        vec_t v;
        v = '{rst: r, pc: pc, opc: opc, in: in, pcj: pcj, nxt: nxt, out: out, ret: ret};
        return v;
    endfunction
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, n_step, act, exp);
        end
    endtask
    task automatic step(vec_t v);
        exp_t e;
        @(posedge clk);
        reset = v.rst;
        bus.pc_cur = v.pc;
        bus.opcode = v.opc;
        {bus.stall, bus.exception, bus.interrupt, bus.set_int, bus.pop_pc, bus.jmp_sgn, bus.push_ack} = v.in;
        bus.pc_jmp = v.pcj;
        bus.pc_popped = 32'd200;
        sb.push_back('{nxt: v.nxt, out: v.out, ret: v.ret});
        #1;
        e = sb.pop_front();
        if (e.out[4]) check("pc_next", bus.pc_next, e.nxt);
        check("pc_load", 32'(bus.pc_load), 32'(e.out[4]));
        check("fetch_nop", 32'(bus.fetch_nop), 32'(e.out[3]));
        check("int_push", 32'(bus.int_push), 32'(e.out[2]));
        check("int_flag", 32'(bus.int_flag), 32'(e.out[1]));
        check("busy", 32'(bus.busy), 32'(e.out[0]));
        check("int_ret_pc", bus.int_ret_pc, e.ret);
        n_step++;
    endtask
    initial begin
        {bus.stall, bus.exception, bus.interrupt, bus.set_int, bus.pop_pc, bus.jmp_sgn, bus.push_ack} = '0;
        bus.pc_cur = '0;
        bus.opcode = '0;
        bus.pc_jmp = '0;
        bus.pc_popped = 32'd200;
        vecs.push_back(mk(1, 0, 0, 0, 0, 32, L|N|B, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 32, L|N|B, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32, L|N|B, 0));
        vecs.push_back(mk(0, 32, 0, 0, 0, 33, L, 0));
        vecs.push_back(mk(0, 33, 0, 0, 0, 34, L, 0));
        vecs.push_back(mk(0, 34, 0, 0, 0, 35, L, 0));
        vecs.push_back(mk(0, 35, 0, PP|JP, 100, 200, L|N, 0));
        vecs.push_back(mk(0, 200, 0, EX|PP|JP, 100, 32, L|N, 0));
        vecs.push_back(mk(0, 32, 0, JP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, L|N, 0));
        vecs.push_back(mk(0, 32'hFFFF_FFFF, 0, 0, 0, 0, L, 0));
        vecs.push_back(mk(0, 0, 0, AK, 0, 1, L, 0));
        vecs.push_back(mk(0, 1, 0, ST|JP, 77, 77, L|N, 0));
        vecs.push_back(mk(0, 77, 8, 0, 0, 78, L, 0));
        vecs.push_back(mk(0, 78, 8, EX, 0, 32, L|N|B, 0));
        vecs.push_back(mk(0, 32, 0, 0, 0, 33, L, 0));
        vecs.push_back(mk(0, 33, 0, IN, 0, 34, L, 0));
        vecs.push_back(mk(0, 34, 0, EX, 0, 32, L|N, 0));
        vecs.push_back(mk(0, 32, 0, 0, 0, 33, L, 0));
        vecs.push_back(mk(0, 33, 8, 0, 0, 34, L, 0));
        vecs.push_back(mk(0, 34, 8, ST, 0, 0, B, 0));
        vecs.push_back(mk(0, 34, 8, 0, 0, 35, L|B, 0));
        vecs.push_back(mk(0, 35, 0, 0, 0, 36, L, 0));
        vecs.push_back(mk(0, 36, 0, JP, 40, 40, L|N, 0));
        vecs.push_back(mk(0, 40, 8, IN, 0, 41, L, 0));
        vecs.push_back(mk(0, 41, 8, 0, 0, 42, L|B, 0));
        vecs.push_back(mk(0, 42, 0, 0, 0, 0, N, 0));
        repeat (2) @(negedge clk);
        foreach (vecs[i]) step(vecs[i]);
        for (int k = 0; k < 3; k++) step(mk(0, 42, 0, 0, 0, 0, N|P|B, 42));
        step(mk(0, 42, 0, AK, 0, 0, N|P|B, 42));
        step(mk(0, 42, 0, 0, 0, 0, L|N|F|B, 42));
        step(mk(0, 0, 0, 0, 0, 1, L, 42));
        step(mk(0, 1, 0, ST|SI, 0, 0, 0, 42));
        for (int k = 0; k < 2; k++) step(mk(0, 1, 0, ST, 0, 0, 0, 42));
        step(mk(0, 1, 0, 0, 0, 0, N, 42));
        step(mk(0, 1, 0, 0, 0, 0, N|P|B, 1));
        step(mk(1, 1, 0, 0, 0, 0, N|B, 1));
        step(mk(0, 1, 0, 0, 0, 32, L|N|B, 0));
        step(mk(0, 32, 0, 0, 0, 33, L, 0));
        step(mk(0, 33, 0, IN, 0, 34, L, 0));
        step(mk(0, 34, 0, 0, 0, 0, N, 0));
        step(mk(0, 34, 0, EX, 0, 32, L|N|B, 34));
        step(mk(0, 32, 0, 0, 0, 33, L, 34));
        step(mk(0, 33, 0, SI, 0, 34, L, 34));
        step(mk(0, 34, 0, 0, 0, 0, N, 34));
        step(mk(0, 34, 0, AK, 0, 0, N|P|B, 34));
        step(mk(0, 34, 0, EX, 0, 32, L|N|B, 34));
        step(mk(0, 32, 0, 0, 0, 33, L, 34));
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Sequencer for the fetch stage's program-counter source. It arbitrates all PC redirect requests: reset, exception, return-PC pop, jump, hardware interrupt and SET_INT. It holds interrupts off while a two-word I-type instruction is in flight. It runs the interrupt-entry handshake that pushes the return PC before vectoring. It sits beside the PC register and drives that register's load value, load enable and the fetch NOP-insert flag.

## Interface
Parameters:
- AW, 32, PC/address width
- RESET_VEC, 32, PC loaded after reset and on exception
- INT_VEC, 0, PC loaded on interrupt entry
- IMM_OPC, 4'd8, opcode (instr[15:12]) of two-word I-type instructions

Ports:
- clk  in  1  single clock; all state updates on falling edge, matching the PC register
- reset  in  1  synchronous, active-high
- pc_cur  in  AW  current PC register value
- opcode  in  4  opcode of the word fetched at pc_cur
- stall  in  1  pipeline stall; PC must hold
- exception  in  1  exception request, single cycle
- interrupt  in  1  external interrupt request, level, latched
- set_int  in  1  SET_INT instruction request, single cycle, latched
- pop_pc  in  1  return-PC pop valid
- pc_popped  in  AW  popped PC value
- jmp_sgn  in  1  taken jump/branch
- pc_jmp  in  AW  jump target
- push_ack  in  1  stack unit accepted int_push
- pc_next  out  AW  value for the PC register
- pc_load  out  1  1 = PC register loads pc_next; 0 = hold
- fetch_nop  out  1  replace the fetched word with 16'd0 this cycle
- int_push  out  1  request to push return PC
- int_ret_pc  out  AW  return PC to push
- int_flag  out  1  interrupt-entry marker to the IF/ID buffer
- busy  out  1  FSM not in RUN

## Operation
- States: RST, RUN, IMM, INT_PUSH, INT_VEC.
- Pending interrupt register int_pend:
  - set by interrupt or set_int in any state;
  - cleared on entry to INT_PUSH, on reset and on exception.
- RST: pc_next=RESET_VEC, pc_load=1, fetch_nop=1 -> RUN.
- RUN, with priorities evaluated in this order:
  1. exception: pc_next=RESET_VEC, fetch_nop=1; stays RUN.
  2. pop_pc: pc_next=pc_popped, fetch_nop=1.
  3. jmp_sgn: pc_next=pc_jmp, fetch_nop=1.
  4. int_pend and not stall: capture int_ret_pc=pc_cur, fetch_nop=1, pc_load=0 -> INT_PUSH.
  5. opcode==IMM_OPC and not stall: pc_next=pc_cur+1 -> IMM.
  6. Otherwise: pc_next=pc_cur+1.
- IMM:
  - Second word is immediate data. It is never decoded as an opcode and interrupts are not taken.
  - pc_next=pc_cur+1 -> RUN.
  - exception, pop_pc or jmp_sgn abort to RUN with the RUN-priority redirect.
- INT_PUSH: int_push=1, pc_load=0, fetch_nop=1 until push_ack; then -> INT_VEC.
- INT_VEC: pc_next=INT_VEC, pc_load=1, int_flag=1, fetch_nop=1 -> RUN.
- stall: pc_load=0 and state frozen in RUN/IMM. Redirects (exception, pop_pc, jmp_sgn) override stall.
- Exception in INT_PUSH/INT_VEC: abort the sequence, drop int_push, load RESET_VEC -> RUN.
- pc_cur+1 wraps modulo 2^AW.

## Timing
- Reset (sampled on a falling edge with reset=1):
  - next state RST, int_pend=0, int_ret_pc=0;
  - outputs in RST as listed above; int_push=0, int_flag=0, busy=1.
- Reset wins over every other input. Reset asserted mid-INT_PUSH drops int_push in the same cycle the state becomes RST.
- Outputs are combinational from state, int_pend and inputs. State, int_pend and int_ret_pc are registered.
- Redirect latency: request in cycle N -> PC holds target after the falling edge ending cycle N. fetch_nop=1 in cycle N.
- Interrupt latency from RUN with no stall: INT_PUSH for k+1 cycles, where k is the push_ack wait (min 0 = ack in same cycle), then INT_VEC for 1 cycle, then the first vector fetch. Minimum 3 cycles from request to fetch at INT_VEC.
- push_ack outside INT_PUSH is ignored.
- An interrupt arriving in IMM is taken on the first RUN cycle after IMM.

## Test plan
- Reset for 2 cycles, release -> one cycle in RST with pc_next=32, then RUN. pc_cur=32,33,34 on successive cycles, fetch_nop=0.
- opcode=8 at pc_cur=40, interrupt raised at pc_cur=40 -> IMM at 41, no interrupt taken. INT_PUSH on the next cycle with int_ret_pc=42.
- In INT_PUSH, push_ack withheld 3 cycles -> int_push=1 for 4 cycles with PC held. Then INT_VEC with pc_next=0 and int_flag=1, then RUN.
- Same cycle: jmp_sgn=1 (pc_jmp=100), pop_pc=1 (pc_popped=200), exception=0 -> PC=200. Add exception=1 -> PC=32.
- stall=1 for 3 cycles with set_int pulsed -> PC frozen, int_pend held. On release -> INT_PUSH.
- Reset asserted during INT_PUSH -> int_push=0 in that cycle, RST, PC=32, int_pend=0. pc_cur=0xFFFFFFFF in RUN -> pc_next=0.
